// File: rtl/key_entry_ctrl.sv
// PS/2 scan-code sequencer feeding a hex-digit entry buffer for a 7-segment display.
// Handles make/break/extended framing and the digit, backspace, clear and enter commands.

module key2Binary (
    input  logic [7:0] i_scan,
    output logic [4:0] o_bin
);
    // Set-2 make codes of the 0-9 and A-F keys; 16 flags a key with no hex meaning
    always_comb begin
        o_bin = 5'd16;
        case (i_scan)
            8'h45: o_bin = 5'd0;
            8'h16: o_bin = 5'd1;
            8'h1E: o_bin = 5'd2;
            8'h26: o_bin = 5'd3;
            8'h25: o_bin = 5'd4;
            8'h2E: o_bin = 5'd5;
            8'h36: o_bin = 5'd6;
            8'h3D: o_bin = 5'd7;
            8'h3E: o_bin = 5'd8;
            8'h46: o_bin = 5'd9;
            8'h1C: o_bin = 5'd10;
            8'h32: o_bin = 5'd11;
            8'h21: o_bin = 5'd12;
            8'h23: o_bin = 5'd13;
            8'h24: o_bin = 5'd14;
            8'h2B: o_bin = 5'd15;
            default: o_bin = 5'd16;
        endcase
    end
endmodule

module key_entry_ctrl #(
    parameter int          N_DIGITS   = 4,
    parameter logic [7:0]  BKSP_CODE  = 8'h66,
    parameter logic [7:0]  ENTER_CODE = 8'h5A,
    parameter logic [7:0]  ESC_CODE   = 8'h76
) (
    input  logic                  clk,
    input  logic                  reset_n,
    input  logic [7:0]            scan_code,
    input  logic                  scan_done_tick,
    output logic [4*N_DIGITS-1:0] digits,
    output logic [N_DIGITS-1:0]   blank,
    output logic [3:0]            digit_cnt,
    output logic [4*N_DIGITS-1:0] value,
    output logic                  value_tick,
    output logic                  err_tick
);
    localparam int         W       = 4 * N_DIGITS;
    localparam logic [3:0] CNT_MAX = 4'(N_DIGITS);

    typedef enum logic [1:0] {S_MAKE, S_BREAK, S_EXT, S_EXT_BRK} state_t;

    state_t                r_state, w_state_next;
    logic                  w_act;
    logic [4:0]            w_key;
    logic [W-1:0]          r_digits, w_digits_next;
    logic [W-1:0]          r_value, w_value_next;
    logic [3:0]            r_cnt, w_cnt_next;
    logic [N_DIGITS-1:0]   r_blank, w_blank_next, w_blank_calc;
    logic                  r_vtick, w_vtick_next;
    logic                  r_err, w_err_next;
    logic                  w_cnt_upd;

    key2Binary u_dec (
        .i_scan (scan_code),
        .o_bin  (w_key)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) r_state <= S_MAKE;
        else          r_state <= w_state_next;
    end

    // Framing: only a byte arriving in MAKE that is not a prefix is acted upon
    always_comb begin
        w_state_next = r_state;
        w_act        = 1'b0;
        if (scan_done_tick) begin
            case (r_state)
                S_MAKE: begin
                    if (scan_code == 8'hF0)      w_state_next = S_BREAK;
                    else if (scan_code == 8'hE0) w_state_next = S_EXT;
                    else                         w_act = 1'b1;
                end
                S_BREAK:   w_state_next = S_MAKE;
                S_EXT:     w_state_next = (scan_code == 8'hF0) ? S_EXT_BRK : S_MAKE;
                S_EXT_BRK: w_state_next = S_MAKE;
                default:   w_state_next = S_MAKE;
            endcase
        end
    end

    always_comb begin
        w_digits_next = r_digits;
        w_cnt_next    = r_cnt;
        w_value_next  = r_value;
        w_vtick_next  = 1'b0;
        w_err_next    = 1'b0;
        w_cnt_upd     = 1'b0;
        if (w_act) begin
            if (scan_code == ENTER_CODE) begin
                w_value_next = r_digits;
                w_vtick_next = 1'b1;
            end else if (scan_code == ESC_CODE) begin
                w_digits_next = '0;
                w_cnt_next    = 4'd0;
                w_cnt_upd     = 1'b1;
            end else if (scan_code == BKSP_CODE) begin
                if (r_cnt != 4'd0) begin
                    w_digits_next = r_digits >> 4;
                    w_cnt_next    = r_cnt - 4'd1;
                    w_cnt_upd     = 1'b1;
                end
            end else if (!w_key[4]) begin
                if (r_cnt < CNT_MAX) begin
                    w_digits_next = (r_digits << 4) | W'(w_key[3:0]);
                    w_cnt_next    = r_cnt + 4'd1;
                    w_cnt_upd     = 1'b1;
                end else begin
                    w_err_next = 1'b1;
                end
            end else begin
                w_err_next = 1'b1;
            end
        end
        w_blank_next = w_cnt_upd ? w_blank_calc : r_blank;
    end

    // Position 0 is never blanked so an empty buffer still shows a single '0'
    genvar gi;
    generate
        for (gi = 0; gi < N_DIGITS; gi++) begin : g_blank
            if (gi == 0) begin : g_first
                assign w_blank_calc[gi] = 1'b0;
            end else begin : g_rest
                assign w_blank_calc[gi] = (w_cnt_next <= 4'(gi));
            end
        end
    endgenerate

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_digits <= '0;
            r_cnt    <= 4'd0;
            r_value  <= '0;
            r_blank  <= '1;
            r_vtick  <= 1'b0;
            r_err    <= 1'b0;
        end else begin
            r_digits <= w_digits_next;
            r_cnt    <= w_cnt_next;
            r_value  <= w_value_next;
            r_blank  <= w_blank_next;
            r_vtick  <= w_vtick_next;
            r_err    <= w_err_next;
        end
    end

    assign digits     = r_digits;
    assign blank      = r_blank;
    assign digit_cnt  = r_cnt;
    assign value      = r_value;
    assign value_tick = r_vtick;
    assign err_tick   = r_err;
endmodule

// File: tb/tb_key_entry_ctrl.sv
// Bench for key_entry_ctrl: directed vector table, hand-written reset/back-to-back
// sequences, then random byte streams checked against a queue-based model.

module tb_key_entry_ctrl;
    localparam int N = 4;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [7:0]  scan_code = 8'h00;
    logic        scan_done_tick = 1'b0;
    logic [15:0] digits, value;
    logic [3:0]  blank, digit_cnt;
    logic        value_tick, err_tick;

    int n_vec = 0;
    int n_bad = 0;

    key_entry_ctrl #(.N_DIGITS(N)) dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .scan_code      (scan_code),
        .scan_done_tick (scan_done_tick),
        .digits         (digits),
        .blank          (blank),
        .digit_cnt      (digit_cnt),
        .value          (value),
        .value_tick     (value_tick),
        .err_tick       (err_tick)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  code;
        logic [15:0] d;
        logic [3:0]  cnt;
        logic [3:0]  bl;
        logic [15:0] v;
        logic        vt;
        logic        er;
    } vec_t;
    vec_t tbl[$];

    localparam logic [7:0] HEX [16] = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36, 8'h3D,
                                        8'h3E, 8'h46, 8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B};

    // Reference model: digit queue, oldest digit first (most significant)
    int         m_q[$];
    int         m_value;
    logic [3:0] m_blank;
    bit         m_skip, m_ext, m_vt, m_err;

    function automatic int m_digits();
        int r = 0;
        foreach (m_q[i]) r = r * 16 + m_q[i];
        return r;
    endfunction

    function automatic int decode(logic [7:0] b);
        for (int i = 0; i < 16; i++) if (HEX[i] == b) return i;
        return 16;
    endfunction

    task automatic set_blank();
        for (int i = 0; i < N; i++) m_blank[i] = (i > 0) && (i >= m_q.size());
    endtask

    task automatic model_reset();
        m_q.delete();
        m_value = 0;
        m_blank = 4'hF;
        m_skip = 0; m_ext = 0; m_vt = 0; m_err = 0;
    endtask

    task automatic model_cycle(bit stb, logic [7:0] b);
        int k;
        m_vt = 0;
        m_err = 0;
        if (!stb) return;
        if (m_skip) m_skip = 0;
        else if (m_ext) begin
            m_ext = 0;
            if (b == 8'hF0) m_skip = 1;
        end
        else if (b == 8'hF0) m_skip = 1;
        else if (b == 8'hE0) m_ext = 1;
        else begin
            k = decode(b);
            if (b == 8'h5A) begin
                m_value = m_digits();
                m_vt = 1;
            end else if (b == 8'h76) begin
                m_q.delete();
                set_blank();
            end else if (b == 8'h66) begin
                if (m_q.size() > 0) begin
                    void'(m_q.pop_back());
                    set_blank();
                end
            end else if (k < 16) begin
                if (m_q.size() < N) begin
                    m_q.push_back(k);
                    set_blank();
                end else m_err = 1;
            end else m_err = 1;
        end
    endtask

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_all(string tag, logic [15:0] d, logic [3:0] c, logic [3:0] bl,
                           logic [15:0] v, logic vt, logic er);
        chk({tag, ".digits"}, 32'(digits), 32'(d));
        chk({tag, ".cnt"}, 32'(digit_cnt), 32'(c));
        chk({tag, ".blank"}, 32'(blank), 32'(bl));
        chk({tag, ".value"}, 32'(value), 32'(v));
        chk({tag, ".value_tick"}, 32'(value_tick), 32'(vt));
        chk({tag, ".err_tick"}, 32'(err_tick), 32'(er));
    endtask

    task automatic strobe(logic [7:0] code);
        @(negedge clk);
        scan_code = code;
        scan_done_tick = 1'b1;
        @(posedge clk);
        #1;
        scan_done_tick = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset_n = 1'b0;
        @(posedge clk);
        #2;
        reset_n = 1'b1;
    endtask

    initial begin
        logic [7:0] b;
        bit         stb;

        tbl.push_back('{8'h16, 16'h0001, 4'd1, 4'b1110, 16'h0000, 1'b0, 1'b0});
        tbl.push_back('{8'h1E, 16'h0012, 4'd2, 4'b1100, 16'h0000, 1'b0, 1'b0});
        tbl.push_back('{8'h26, 16'h0123, 4'd3, 4'b1000, 16'h0000, 1'b0, 1'b0});
        tbl.push_back('{8'h1C, 16'h123A, 4'd4, 4'b0000, 16'h0000, 1'b0, 1'b0});
        tbl.push_back('{8'hF0, 16'h123A, 4'd4, 4'b0000, 16'h0000, 1'b0, 1'b0});
        tbl.push_back('{8'h1C, 16'h123A, 4'd4, 4'b0000, 16'h0000, 1'b0, 1'b0});
        tbl.push_back('{8'h2B, 16'h123A, 4'd4, 4'b0000, 16'h0000, 1'b0, 1'b1});
        tbl.push_back('{8'h66, 16'h0123, 4'd3, 4'b1000, 16'h0000, 1'b0, 1'b0});
        tbl.push_back('{8'h5A, 16'h0123, 4'd3, 4'b1000, 16'h0123, 1'b1, 1'b0});
        tbl.push_back('{8'h76, 16'h0000, 4'd0, 4'b1110, 16'h0123, 1'b0, 1'b0});
        tbl.push_back('{8'hE0, 16'h0000, 4'd0, 4'b1110, 16'h0123, 1'b0, 1'b0});
        tbl.push_back('{8'h75, 16'h0000, 4'd0, 4'b1110, 16'h0123, 1'b0, 1'b0});
        tbl.push_back('{8'hE0, 16'h0000, 4'd0, 4'b1110, 16'h0123, 1'b0, 1'b0});
        tbl.push_back('{8'hF0, 16'h0000, 4'd0, 4'b1110, 16'h0123, 1'b0, 1'b0});
        tbl.push_back('{8'h75, 16'h0000, 4'd0, 4'b1110, 16'h0123, 1'b0, 1'b0});
        tbl.push_back('{8'h29, 16'h0000, 4'd0, 4'b1110, 16'h0123, 1'b0, 1'b1});
        tbl.push_back('{8'h66, 16'h0000, 4'd0, 4'b1110, 16'h0123, 1'b0, 1'b0});
        tbl.push_back('{8'h5A, 16'h0000, 4'd0, 4'b1110, 16'h0000, 1'b1, 1'b0});
        tbl.push_back('{8'h45, 16'h0000, 4'd1, 4'b1110, 16'h0000, 1'b0, 1'b0});

        repeat (2) @(posedge clk);
        #2;
        reset_n = 1'b1;
        chk_all("reset", 16'h0, 4'd0, 4'b1111, 16'h0, 1'b0, 1'b0);

        for (int i = 0; i < tbl.size(); i++) begin
            strobe(tbl[i].code);
            chk_all($sformatf("vec%0d", i), tbl[i].d, tbl[i].cnt, tbl[i].bl, tbl[i].v,
                    tbl[i].vt, tbl[i].er);
            @(posedge clk);
            #1;
            chk_all($sformatf("vec%0d_idle", i), tbl[i].d, tbl[i].cnt, tbl[i].bl, tbl[i].v,
                    1'b0, 1'b0);
        end

        // Reset while in BREAK: the following byte must be taken as a make code
        strobe(8'hF0);
        do_reset();
        chk_all("mid_reset", 16'h0, 4'd0, 4'b1111, 16'h0, 1'b0, 1'b0);
        strobe(8'h45);
        chk_all("after_reset_45", 16'h0, 4'd1, 4'b1110, 16'h0, 1'b0, 1'b0);

        // Back-to-back strobes on adjacent clocks
        @(negedge clk);
        scan_code = 8'h16;
        scan_done_tick = 1'b1;
        @(posedge clk);
        #1;
        chk_all("b2b_first", 16'h0001, 4'd2, 4'b1100, 16'h0, 1'b0, 1'b0);
        @(negedge clk);
        scan_code = 8'h1E;
        @(posedge clk);
        #1;
        scan_done_tick = 1'b0;
        chk_all("b2b_second", 16'h0012, 4'd3, 4'b1000, 16'h0, 1'b0, 1'b0);

        // Random byte streams against the model
        do_reset();
        model_reset();
        for (int c = 0; c < 600; c++) begin
            @(negedge clk);
            stb = ($urandom_range(0, 3) != 0);
            case ($urandom_range(0, 10))
                0, 1, 2, 3: b = HEX[$urandom_range(0, 15)];
                4:          b = 8'hF0;
                5:          b = 8'hE0;
                6, 7:       b = 8'h66;
                8:          b = 8'h5A;
                9:          b = 8'h76;
                default:    b = 8'($urandom_range(0, 255));
            endcase
            scan_code = b;
            scan_done_tick = stb;
            @(posedge clk);
            #1;
            model_cycle(stb, b);
            chk_all($sformatf("rnd%0d", c), 16'(m_digits()), 4'(m_q.size()), m_blank,
                    16'(m_value), m_vt, m_err);
        end
        scan_done_tick = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end
endmodule
